// File: rtl/arm_pkg.sv
// arm_pkg: shared FSM encoding, one-hot phase indices and opcode constants for the sequencer.
package arm_pkg;
  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC1 = 3'd1,
    S_MEM   = 3'd2,
    S_EXEC2 = 3'd3,
    S_HALT  = 3'd4
  } fsm_e;
  localparam int ST_FETCH = 0;
  localparam int ST_EXEC1 = 1;
  localparam int ST_EXEC2 = 2;
  localparam logic [3:0] OP_LDR = 4'b1110;
  localparam logic [3:0] OP_JMP = 4'b0001;
  localparam logic [15:0] DEF_HALT_WORD = 16'h0FFF;
  function automatic logic [15:0] sext12(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction
endpackage

// File: rtl/arm_sequencer.sv
// arm_sequencer: fetch/execute controller owning the PC, instruction fetch and LDR data-load handshakes.
module arm_sequencer
  import arm_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = DEF_HALT_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic [15:0] rs_data,
  output logic        dmem_req,
  output logic [15:0] dmem_addr,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic [2:0]  state,
  output logic [15:0] inst,
  output logic [15:0] pc,
  output logic [15:0] ld_data,
  output logic        halted,
  output logic [15:0] instr_count
);
  fsm_e fsm_q, fsm_d;
  logic [15:0] pc_q, pc_d, inst_q, inst_d, daddr_q, daddr_d, ld_q, ld_d, cnt_q, cnt_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= S_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      daddr_q <= '0;
      ld_q    <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      daddr_q <= daddr_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    fsm_d   = fsm_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    daddr_d = daddr_q;
    ld_d    = ld_q;
    cnt_d   = cnt_q;
    case (fsm_q)
      S_FETCH: if (imem_ack) begin
        inst_d = imem_rdata;
        pc_d   = pc_q + 16'd1;
        fsm_d  = (imem_rdata == HALT_WORD) ? S_HALT : S_EXEC1;
      end
      S_EXEC1: if (inst_q[15:12] == OP_LDR) begin
        daddr_d = rs_data;
        fsm_d   = S_MEM;
      end else begin
        // pc already points past the JMP, so step back to make the offset relative to the JMP itself
        pc_d  = (inst_q[15:12] == OP_JMP) ? pc_q - 16'd1 + sext12(inst_q[11:0]) : pc_q;
        cnt_d = cnt_q + 16'd1;
        fsm_d = S_FETCH;
      end
      S_MEM: if (dmem_ack) begin
        ld_d  = dmem_rdata;
        fsm_d = S_EXEC2;
      end
      S_EXEC2: begin
        cnt_d = cnt_q + 16'd1;
        fsm_d = S_FETCH;
      end
      default: ;
    endcase
  end
  always_comb begin
    state           = '0;
    state[ST_FETCH] = fsm_q == S_FETCH;
    state[ST_EXEC1] = fsm_q == S_EXEC1;
    state[ST_EXEC2] = fsm_q == S_EXEC2;
  end
  assign imem_req    = fsm_q == S_FETCH;
  assign dmem_req    = fsm_q == S_MEM;
  assign halted      = fsm_q == S_HALT;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign inst        = inst_q;
  assign dmem_addr   = daddr_q;
  assign ld_data     = ld_q;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_arm_sequencer.sv
// tb_arm_sequencer: directed table, randomized ISA-level reference check, halt and reset corner cases.
module tb_arm_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req, dmem_req, halted;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0;
  logic [15:0] imem_addr, dmem_addr, inst, pc, ld_data, instr_count;
  logic [15:0] imem_rdata = '0, rs_data = '0, dmem_rdata = '0;
  logic [2:0]  state;
  int tests = 0, fails = 0;

  arm_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .rs_data(rs_data),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .state(state), .inst(inst), .pc(pc), .ld_data(ld_data), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ins, rs, drd;
    int          iw, dw;
    logic [15:0] exp_pc, exp_cnt, exp_ld;
    int          exp_cyc, exp_mem;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Serves one instruction with the given memory wait states; called and returns at a negedge in FETCH.
  task automatic exec(input logic [15:0] ins, rs, drd, input int iw, dw, input bit noise,
                      output int cyc, output int nmem, output bit addr_ok, output bit to);
    int ic = 0, dc = 0;
    bit left = 0;
    cyc = 0; nmem = 0; addr_ok = 1; to = 1;
    for (int k = 0; k < 200; k++) begin
      if (dmem_req) begin
        nmem++;
        if (dmem_addr !== rs) addr_ok = 0;
      end
      imem_rdata = ins;
      imem_ack   = imem_req ? (ic == iw) : (noise && $urandom_range(0, 1) == 1);
      if (imem_req) ic++;
      dmem_rdata = drd;
      dmem_ack   = dmem_req ? (dc == dw) : (noise && $urandom_range(0, 1) == 1);
      if (dmem_req) dc++;
      rs_data = (state == 3'b010) ? rs : ~rs;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (state != 3'b001) left = 1;
      if ((left && state == 3'b001) || halted) begin
        to = 0;
        break;
      end
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  vec_t vecs[10];
  int cyc, nmem;
  bit aok, to;
  logic [15:0] m_pc, m_cnt, m_ld, ins, rs, drd;
  int iw, dw, r;

  initial begin
    vecs[0] = '{16'h0312, 16'h0000, 16'h0000, 0, 0, 16'h0001, 16'd1,  16'h0000, 2, 0};
    vecs[1] = '{16'hE012, 16'h0040, 16'hBEEF, 0, 3, 16'h0002, 16'd2,  16'hBEEF, 7, 4};
    vecs[2] = '{16'h0000, 16'h0000, 16'h0000, 2, 0, 16'h0003, 16'd3,  16'hBEEF, 4, 0};
    vecs[3] = '{16'h1002, 16'h0000, 16'h0000, 0, 0, 16'h0005, 16'd4,  16'hBEEF, 2, 0};
    vecs[4] = '{16'h1FFE, 16'h0000, 16'h0000, 0, 0, 16'h0003, 16'd5,  16'hBEEF, 2, 0};
    vecs[5] = '{16'h1000, 16'h0000, 16'h0000, 0, 0, 16'h0003, 16'd6,  16'hBEEF, 2, 0};
    vecs[6] = '{16'h1000, 16'h0000, 16'h0000, 0, 0, 16'h0003, 16'd7,  16'hBEEF, 2, 0};
    vecs[7] = '{16'hE555, 16'h1234, 16'h0000, 1, 0, 16'h0004, 16'd8,  16'h0000, 5, 1};
    vecs[8] = '{16'h1FFB, 16'h0000, 16'h0000, 0, 0, 16'hFFFF, 16'd9,  16'h0000, 2, 0};
    vecs[9] = '{16'h0123, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'd10, 16'h0000, 2, 0};

    @(negedge clk);
    chk("rst_ctl", {state, imem_req, dmem_req, halted}, {3'b001, 1'b1, 1'b0, 1'b0});
    chk("rst_pc", pc, 16'h0000);
    chk("rst_regs", {inst, ld_data}, 32'h0);
    chk("rst_daddr_cnt", {dmem_addr, instr_count}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      exec(vecs[i].ins, vecs[i].rs, vecs[i].drd, vecs[i].iw, vecs[i].dw, 1'b0, cyc, nmem, aok, to);
      chk($sformatf("v%0d_timeout", i), to, 0);
      chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_cnt", i), instr_count, vecs[i].exp_cnt);
      chk($sformatf("v%0d_ld", i), ld_data, vecs[i].exp_ld);
      chk($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cyc);
      chk($sformatf("v%0d_mem_cycles", i), nmem, vecs[i].exp_mem);
      chk($sformatf("v%0d_daddr_ok", i), aok, 1);
      chk($sformatf("v%0d_inst", i), inst, vecs[i].ins);
    end

    // count wrap: preset the retire counter rather than retiring 65535 NOPs
    force dut.cnt_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.cnt_q;
    chk("cnt_preset", instr_count, 16'hFFFF);
    exec(16'h0000, 16'h0, 16'h0, 0, 0, 1'b0, cyc, nmem, aok, to);
    chk("cnt_wrap", instr_count, 16'h0000);
    chk("cnt_wrap_pc", pc, 16'h0001);

    do_reset();
    m_pc = 16'h0; m_cnt = 16'h0; m_ld = 16'h0;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3) ins = {4'hE, 12'($urandom)};
      else if (r < 5) ins = {4'h1, 12'($urandom)};
      else begin
        ins = 16'($urandom);
        if (ins[15:12] == 4'hE || ins[15:12] == 4'h1) ins[15:12] = 4'h2;
        if (ins == 16'h0FFF) ins = 16'h0FFE;
      end
      rs = 16'($urandom); drd = 16'($urandom);
      iw = $urandom_range(0, 2); dw = $urandom_range(0, 3);
      exec(ins, rs, drd, iw, dw, 1'b1, cyc, nmem, aok, to);
      if (ins[15:12] == 4'hE) begin
        m_ld = drd;
        m_pc = m_pc + 16'd1;
      end else if (ins[15:12] == 4'h1) m_pc = m_pc + {{4{ins[11]}}, ins[11:0]};
      else m_pc = m_pc + 16'd1;
      m_cnt = m_cnt + 16'd1;
      chk($sformatf("rnd%0d_timeout", n), to, 0);
      chk($sformatf("rnd%0d_pc", n), pc, m_pc);
      chk($sformatf("rnd%0d_cnt", n), instr_count, m_cnt);
      chk($sformatf("rnd%0d_ld", n), ld_data, m_ld);
      chk($sformatf("rnd%0d_cycles", n), cyc, iw + 2 + (ins[15:12] == 4'hE ? dw + 2 : 0));
      chk($sformatf("rnd%0d_daddr_ok", n), aok, 1);
    end

    exec(16'h0FFF, 16'h0, 16'h0, 1, 0, 1'b0, cyc, nmem, aok, to);
    chk("halt_entry", to, 0);
    chk("halt_cycles", cyc, 2);
    chk("halt_pc", pc, m_pc + 16'd1);
    chk("halt_cnt", instr_count, m_cnt);
    for (int k = 0; k < 25; k++) begin
      imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
      imem_rdata = 16'($urandom); dmem_rdata = 16'($urandom); rs_data = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("halt_hold_ctl", {state, halted, imem_req, dmem_req}, {3'b000, 1'b1, 1'b0, 1'b0});
      chk("halt_hold_pc_cnt", {pc, instr_count}, {m_pc + 16'd1, m_cnt});
      chk("halt_hold_ld", ld_data, m_ld);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;

    do_reset();
    imem_rdata = 16'hE000; imem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    imem_ack = 1'b0; rs_data = 16'h0040;
    @(posedge clk);
    @(negedge clk);
    chk("mid_mem_req", {state, dmem_req}, {3'b000, 1'b1});
    chk("mid_mem_addr", dmem_addr, 16'h0040);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", {state, imem_req, dmem_req}, {3'b001, 1'b1, 1'b0});
    chk("async_rst_pc", pc, 16'h0000);
    chk("async_rst_daddr", dmem_addr, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("late_ack_ctl", {state, dmem_req}, {3'b001, 1'b0});
    chk("late_ack_ld", ld_data, 16'h0000);
    chk("late_ack_pc_cnt", {pc, instr_count}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/arm_sequencer.md
Name: arm_sequencer

Overview:
- Fetch/execute controller for the 16-bit Harvard no-pipeline core.
- It is the other end of the ALU's control interface: it produces the one-hot `state[2:0]` and the latched `inst[15:0]` that the ALU consumes.
- It owns the PC, the instruction-memory fetch handshake and the data-memory read handshake for LDR.
- It supplies `ld_data` to the writeback mux; LDR writeback happens on the single EXEC2 cycle.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_WORD, 16'h0FFF, instruction encoding that stops the core.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request, high throughout FETCH.
- imem_addr  out  16  equals pc.
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  16  instruction word.
- rs_data  in  16  register-file Rs read port, used as LDR address.
- dmem_req  out  1  load request, high throughout MEM.
- dmem_addr  out  16  registered load address.
- dmem_ack  in  1  load complete; dmem_rdata valid this cycle.
- dmem_rdata  in  16  load data.
- state  out  3  one-hot phase: [0]=FETCH, [1]=EXEC1, [2]=EXEC2; 3'b000 in MEM and HALT.
- inst  out  16  current instruction register.
- pc  out  16  program counter, word address.
- ld_data  out  16  registered load data for writeback.
- halted  out  1  high in HALT.
- instr_count  out  16  retired-instruction counter.

Behaviour:
- Reset values (async, rst_n=0):
  - FSM=FETCH, so state=3'b001 and imem_req=1.
  - pc=RESET_PC.
  - inst=16'h0000, ld_data=0, dmem_addr=0, instr_count=0.
  - dmem_req=0, halted=0.
- Reset mid-operation aborts any outstanding request; memories discard it.
- FSM states: FETCH, EXEC1, MEM, EXEC2, HALT. imem_req=(FETCH), dmem_req=(MEM); both combinational from FSM.
- FETCH:
  - Wait for imem_ack; an ack in the same cycle as req is legal.
  - On ack: inst<=imem_rdata, pc<=pc+1 (mod 2^16), go to EXEC1.
  - A fetched word equal to HALT_WORD goes to HALT instead of EXEC1 and is not counted.
- EXEC1 (exactly 1 cycle):
  - inst[15:12]==4'b1110 (LDR): dmem_addr<=rs_data, go to MEM.
  - inst[15:12]==4'b0001 (JMP): pc<=pc-1+sext(inst[11:0]), so the target is the JMP's own address plus the offset; wraps mod 2^16. Go to FETCH, instr_count+1.
  - All other instructions: go to FETCH, instr_count+1.
- MEM: wait for dmem_ack. On ack: ld_data<=dmem_rdata, go to EXEC2.
- EXEC2: exactly 1 cycle. Go to FETCH, instr_count+1. The LDR register write happens on this cycle only.
- HALT: state=3'b000, halted=1. Leaves only on reset. pc holds the address after the halt word.
- Latency (cycles from FETCH entry, with zero-wait memories):
  - Non-LDR: FETCH 1 + EXEC1 1 = 2 per instruction.
  - LDR: 1 + 1 + 1 + 1 = 4.
  - Each wait cycle on a memory adds exactly 1.
- imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- inst is stable from EXEC1 entry until the next fetch ack. dmem_addr is stable throughout MEM.
- instr_count wraps 16'hFFFF -> 16'h0000.
- pc wraps 16'hFFFF -> 16'h0000 on the fetch increment.

Decomposition:
- Shared package arm_pkg:
  - FSM encoding enum.
  - State one-hot bit indices (ST_FETCH=0, ST_EXEC1=1, ST_EXEC2=2).
  - Opcode constants OP_LDR=4'b1110 and OP_JMP=4'b0001.
  - Default HALT_WORD.
- Single module; no sub-module warranted.

Test Plan:
- Reset release, imem returns 16'h0312 with zero-wait ack:
  - state sequence 001,010,001; pc 0->1; instr_count=1.
- LDR 16'hE012 at address 0, rs_data=16'h0040, dmem ack after 3 wait cycles returning 16'hBEEF:
  - dmem_addr=16'h0040; MEM lasts 4 cycles.
  - EXEC2 lasts 1 cycle with ld_data=16'hBEEF; then FETCH with pc=1.
- JMP 16'h1FFE at address 16'h0005:
  - next fetch address 16'h0003.
  - JMP 16'h1000 fetches the same address repeatedly; instr_count increments each loop.
- pc=16'hFFFF, fetch a non-JMP:
  - pc wraps to 16'h0000.
  - Preload instr_count to 16'hFFFF via 65535 NOPs, or force it in the bench; the next retire gives 16'h0000.
- Fetch HALT_WORD 16'h0FFF:
  - halted=1, state=000, imem_req=0 for 20+ cycles, instr_count unchanged.
  - Spurious imem_ack/dmem_ack pulses have no effect.
- Assert rst_n=0 mid-MEM (dmem_req=1):
  - dmem_req drops immediately; state=001; pc=RESET_PC.
  - A late dmem_ack after reset release is ignored.
